// File: rtl/cpu_pkg.sv
// Shared definitions for the 32-bit, 3-bit-opcode core control path.
// Contents:
//   - opcode encodings (OP_NOOP .. OP_SUBI)
//   - ALU operation encodings (ALU_ADD, ALU_SUB, ALU_SHL)
//   - sequencer FSM state enum (state_t)
//   - instruction field bit positions
package cpu_pkg;

  localparam logic [2:0] OP_NOOP    = 3'b000;
  localparam logic [2:0] OP_J       = 3'b001;
  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_BEQ     = 3'b011;
  localparam logic [2:0] OP_SHIFTL  = 3'b100;
  localparam logic [2:0] OP_ILLEGAL = 3'b101;
  localparam logic [2:0] OP_ADDI    = 3'b110;
  localparam logic [2:0] OP_SUBI    = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_SHL = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  // Instruction field positions. Note rd, imm16 and target overlap on
  // purpose; which one is meaningful depends on the opcode.
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 29;
  localparam int RS_HI  = 28;
  localparam int RS_LO  = 24;
  localparam int RT_HI  = 23;
  localparam int RT_LO  = 19;
  localparam int RD_HI  = 18;
  localparam int RD_LO  = 14;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 13;
  localparam int TGT_LO = 0;

  localparam int REG_FIELD_W = 5;
  localparam int TGT_W       = 14;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and the instruction memory / register
// file / ALU datapath.
// Parameters: PC_W (address width), RF_AW (register index width).
// Signals:
//   imem_addr   word address to instruction memory
//   imem_data   instruction word, valid combinationally from imem_addr
//   rf_ra1/2    register read indices
//   rf_wa/rf_we register write index and one-cycle write strobe
//   alu_op      00 ADD, 01 SUB, 10 SHL
//   alu_src_imm ALU B operand is imm
//   imm         zero-extended 16-bit immediate
//   alu_zero    ALU result is zero
// Modports: master = sequencer, slave = memory/datapath side.
//
// Handshake semantics: there is no valid/ready pair on this bus. Instruction
// memory answers combinationally in the same cycle imem_addr is presented,
// the read indices and ALU controls are plain levels that hold from DECODE
// through WB, and rf_we is a single-cycle write strobe that the register
// file must act on in the cycle it is high (it can never be stalled).
interface fetch_sequencer_if #(
  parameter int PC_W  = 32,
  parameter int RF_AW = 5
);
  logic [PC_W-1:0]  imem_addr;
  logic [31:0]      imem_data;
  logic [RF_AW-1:0] rf_ra1;
  logic [RF_AW-1:0] rf_ra2;
  logic [RF_AW-1:0] rf_wa;
  logic             rf_we;
  logic [1:0]       alu_op;
  logic             alu_src_imm;
  logic [31:0]      imm;
  logic             alu_zero;

  modport master (
    output imem_addr, rf_ra1, rf_ra2, rf_wa, rf_we, alu_op, alu_src_imm, imm,
    input  imem_data, alu_zero
  );

  modport slave (
    input  imem_addr, rf_ra1, rf_ra2, rf_wa, rf_we, alu_op, alu_src_imm, imm,
    output imem_data, alu_zero
  );
endinterface

// File: rtl/fetch_sequencer_instr_field_decode.sv
// instr_field_decode: purely combinational split of the instruction register
// into its fields and opcode class flags.
// Ports:
//   ir          in  32  latched instruction word
//   op          out 3   opcode
//   rs, rt, rd  out 5   register fields
//   imm         out 32  IR[15:0] zero-extended
//   target      out 14  absolute jump/branch word address
//   is_alu      out 1   ADD, SHIFTL, ADDI, SUBI (needs a WB cycle)
//   is_imm      out 1   ADDI, SUBI (immediate operand, writes rt)
//   is_branch   out 1   BEQ
//   is_jump     out 1   J
//   is_illegal  out 1   opcode 101
module instr_field_decode
  import cpu_pkg::*;
(
  input  logic [31:0]            ir,
  output logic [2:0]             op,
  output logic [REG_FIELD_W-1:0] rs,
  output logic [REG_FIELD_W-1:0] rt,
  output logic [REG_FIELD_W-1:0] rd,
  output logic [31:0]            imm,
  output logic [TGT_W-1:0]       target,
  output logic                   is_alu,
  output logic                   is_imm,
  output logic                   is_branch,
  output logic                   is_jump,
  output logic                   is_illegal
);

  assign op     = ir[OP_HI:OP_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign imm    = {16'h0000, ir[IMM_HI:IMM_LO]};
  assign target = ir[TGT_HI:TGT_LO];

  always_comb begin
    is_alu     = 1'b0;
    is_imm     = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_ADD, OP_SHIFTL: is_alu = 1'b1;
      OP_ADDI, OP_SUBI: begin
        is_alu = 1'b1;
        is_imm = 1'b1;
      end
      OP_BEQ:     is_branch  = 1'b1;
      OP_J:       is_jump    = 1'b1;
      OP_ILLEGAL: is_illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle control unit. Owns the PC and instruction
// register and steps every instruction through FETCH -> DECODE -> EXEC
// (-> WB for ALU instructions). J and BEQ are resolved in EXEC.
// Parameters: PC_W (PC width, default 32), RF_AW (register index width, 5).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   run         level enable, only looked at in FETCH
//   step        (only with FETCH_SEQUENCER_SINGLE_STEP_EN) FETCH advances
//               only when run && step
//   bus         fetch_sequencer_if.master: imem, register file, ALU controls
//   pc          current program counter
//   retire      one-cycle pulse on an instruction's last cycle
//   illegal     one-cycle pulse when opcode 101 retires
//   state       current FSM state (debug visibility)
// Build option: define FETCH_SEQUENCER_SINGLE_STEP_EN to add the step port.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
  input  logic             step,
`endif
  fetch_sequencer_if.master bus,
  output logic [PC_W-1:0]  pc,
  output logic             retire,
  output logic             illegal,
  output state_t           state
);

  state_t                   state_q, state_d;
  logic [31:0]              ir_q;
  logic [PC_W-1:0]          pc_q, pc_next, pc_inc, pc_target;
  logic                     pc_load;
  logic                     fetch_go;

  logic [2:0]               op;
  logic [REG_FIELD_W-1:0]   rs, rt, rd, dest;
  logic [31:0]              imm_w;
  logic [TGT_W-1:0]         target;
  logic                     is_alu, is_imm, is_branch, is_jump, is_illegal;

  logic                     rf_we_c, retire_c, illegal_c;
  logic [1:0]               alu_op_c;

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
  assign fetch_go = run && step;
`else
  assign fetch_go = run;
`endif

  instr_field_decode u_decode (
    .ir         (ir_q),
    .op         (op),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm        (imm_w),
    .target     (target),
    .is_alu     (is_alu),
    .is_imm     (is_imm),
    .is_branch  (is_branch),
    .is_jump    (is_jump),
    .is_illegal (is_illegal)
  );

  // Immediate forms write rt; register forms write rd.
  assign dest = is_imm ? rt : rd;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (fetch_go) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = is_alu ? ST_WB : ST_FETCH;
      ST_WB:     state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Strobes come straight from the state register so they drop the moment
  // reset is asserted. ALU controls are a function of IR alone, so they hold
  // steady from DECODE through WB without extra registers.
  always_comb begin
    rf_we_c   = 1'b0;
    retire_c  = 1'b0;
    illegal_c = 1'b0;
    case (state_q)
      ST_EXEC: begin
        if (!is_alu) begin
          retire_c  = 1'b1;
          illegal_c = is_illegal;
        end
      end
      ST_WB: begin
        retire_c = 1'b1;
        rf_we_c  = (dest != '0);
      end
      default: ;
    endcase

    case (op)
      OP_SUBI, OP_BEQ: alu_op_c = ALU_SUB;
      OP_SHIFTL:       alu_op_c = ALU_SHL;
      default:         alu_op_c = ALU_ADD;
    endcase
  end

  // ---------------- PC / IR ----------------
  assign pc_inc    = pc_q + PC_W'(1);
  assign pc_target = PC_W'(target);

  always_comb begin
    pc_load = 1'b0;
    pc_next = pc_inc;
    case (state_q)
      ST_EXEC: begin
        if (is_jump) begin
          pc_load = 1'b1;
          pc_next = pc_target;
        end else if (is_branch) begin
          pc_load = 1'b1;
          pc_next = bus.alu_zero ? pc_target : pc_inc;
        end else if (!is_alu) begin
          pc_load = 1'b1;
        end
      end
      ST_WB:   pc_load = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      ir_q <= '0;
    end else begin
      if (state_q == ST_FETCH && fetch_go) ir_q <= bus.imem_data;
      if (pc_load)                         pc_q <= pc_next;
    end
  end

  // ---------------- outputs ----------------
  assign bus.imem_addr   = pc_q;
  assign bus.rf_ra1      = RF_AW'(rs);
  assign bus.rf_ra2      = RF_AW'(rt);
  assign bus.rf_wa       = RF_AW'(dest);
  assign bus.rf_we       = rf_we_c;
  assign bus.alu_op      = alu_op_c;
  assign bus.alu_src_imm = is_imm;
  assign bus.imm         = imm_w;

  assign pc      = pc_q;
  assign retire  = retire_c;
  assign illegal = illegal_c;
  assign state   = state_q;

endmodule
